// File: rtl/cpu_pkg.sv
// Shared CPU encodings: opcodes, control-unit states and bus mux selects.
// The datapath muxes decode the same select values.
package cpu_pkg;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_ADD = 4'd1,
        OP_SUB = 4'd2,
        OP_AND = 4'd3,
        OP_NOT = 4'd4,
        OP_RD  = 4'd5,
        OP_WR  = 4'd6,
        OP_BR  = 4'd7,
        OP_BRZ = 4'd8
    } opcode_e;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_FET1 = 4'd1,
        S_FET2 = 4'd2,
        S_DEC  = 4'd3,
        S_EX1  = 4'd4,
        S_RD1  = 4'd5,
        S_RD2  = 4'd6,
        S_WR1  = 4'd7,
        S_WR2  = 4'd8,
        S_BR1  = 4'd9,
        S_BR2  = 4'd10,
        S_HALT = 4'd11
    } state_e;

    typedef logic [2:0] sel1_t;
    typedef logic [1:0] sel2_t;

    localparam sel1_t SEL1_R0 = 3'd0;
    localparam sel1_t SEL1_R1 = 3'd1;
    localparam sel1_t SEL1_R2 = 3'd2;
    localparam sel1_t SEL1_R3 = 3'd3;
    localparam sel1_t SEL1_PC = 3'd4;

    localparam sel2_t SEL2_ALU  = 2'd0;
    localparam sel2_t SEL2_BUS1 = 2'd1;
    localparam sel2_t SEL2_MEM  = 2'd2;

endpackage

// File: rtl/control_unit_if.sv
// Control unit <-> datapath connection: instruction/flag inputs, strobes,
// bus selects and the debug state.
interface control_unit_if
    import cpu_pkg::*;
#(
    parameter int word_size  = 8,
    parameter int state_size = 4
);
    logic [word_size-1:0]  instruction;
    logic                  zero;
    logic                  load_r0;
    logic                  load_r1;
    logic                  load_r2;
    logic                  load_r3;
    logic                  load_pc;
    logic                  inc_pc;
    logic                  load_ir;
    logic                  load_add_r;
    logic                  load_reg_y;
    logic                  load_reg_z;
    logic                  write;
    sel1_t                 sel_bus_1_mux;
    sel2_t                 sel_bus_2_mux;
    logic [state_size-1:0] state;

    modport master (
        input  instruction, zero,
        output load_r0, load_r1, load_r2, load_r3, load_pc, inc_pc, load_ir,
               load_add_r, load_reg_y, load_reg_z, write,
               sel_bus_1_mux, sel_bus_2_mux, state
    );

    modport slave (
        output instruction, zero,
        input  load_r0, load_r1, load_r2, load_r3, load_pc, inc_pc, load_ir,
               load_add_r, load_reg_y, load_reg_z, write,
               sel_bus_1_mux, sel_bus_2_mux, state
    );
endinterface

// File: rtl/control_unit.sv
// Multi-cycle CPU control unit: fetch/decode/execute sequencer driving
// datapath strobes and bus selects. Outputs decode purely from state/inputs.
//   IDLE   | out of reset          FET1 | PC -> address reg
//   FET2   | mem -> IR, PC++        DEC  | decode, single-cycle ops finish here
//   EX1    | ALU result -> R[dest]  RD1/RD2 | operand addr, mem -> R[dest]
//   WR1/WR2 | operand addr, R[src] -> mem   BR1/BR2 | target fetch, mem -> PC
//   HALT   | illegal opcode, held until reset
module control_unit
    import cpu_pkg::*;
#(
    parameter int word_size  = 8,
    parameter int op_size    = 4,
    parameter int state_size = 4
) (
    input logic            clk,
    input logic            rst,
    control_unit_if.master cu
);

    logic [state_size-1:0] state_q;
    logic [state_size-1:0] state_d;
    logic [op_size-1:0]    opcode;
    logic [1:0]            src;
    logic [1:0]            dest;
    logic [3:0]            load_r;
    logic                  load_pc;
    logic                  inc_pc;
    logic                  load_ir;
    logic                  load_add_r;
    logic                  load_reg_y;
    logic                  load_reg_z;
    logic                  write;
    sel1_t                 sel1;
    sel2_t                 sel2;

    assign opcode = cu.instruction[word_size-1 -: op_size];
    assign src    = cu.instruction[3:2];
    assign dest   = cu.instruction[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= state_size'(S_IDLE);
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        load_r     = 4'b0000;
        load_pc    = 1'b0;
        inc_pc     = 1'b0;
        load_ir    = 1'b0;
        load_add_r = 1'b0;
        load_reg_y = 1'b0;
        load_reg_z = 1'b0;
        write      = 1'b0;
        sel1       = SEL1_R0;
        sel2       = SEL2_ALU;

        case (state_q)
            state_size'(S_IDLE): begin
                state_d = state_size'(S_FET1);
            end
            state_size'(S_FET1): begin
                sel1       = SEL1_PC;
                sel2       = SEL2_BUS1;
                load_add_r = 1'b1;
                state_d    = state_size'(S_FET2);
            end
            state_size'(S_FET2): begin
                sel2    = SEL2_MEM;
                load_ir = 1'b1;
                inc_pc  = 1'b1;
                state_d = state_size'(S_DEC);
            end
            state_size'(S_DEC): begin
                case (opcode)
                    op_size'(OP_NOP): begin
                        state_d = state_size'(S_FET1);
                    end
                    op_size'(OP_ADD), op_size'(OP_SUB), op_size'(OP_AND): begin
                        sel1       = {1'b0, src};
                        sel2       = SEL2_BUS1;
                        load_reg_y = 1'b1;
                        state_d    = state_size'(S_EX1);
                    end
                    op_size'(OP_NOT): begin
                        sel1         = {1'b0, src};
                        sel2         = SEL2_ALU;
                        load_reg_z   = 1'b1;
                        load_r[dest] = 1'b1;
                        state_d      = state_size'(S_FET1);
                    end
                    op_size'(OP_RD): begin
                        sel1       = SEL1_PC;
                        sel2       = SEL2_BUS1;
                        load_add_r = 1'b1;
                        state_d    = state_size'(S_RD1);
                    end
                    op_size'(OP_WR): begin
                        sel1       = SEL1_PC;
                        sel2       = SEL2_BUS1;
                        load_add_r = 1'b1;
                        state_d    = state_size'(S_WR1);
                    end
                    op_size'(OP_BR): begin
                        sel1       = SEL1_PC;
                        sel2       = SEL2_BUS1;
                        load_add_r = 1'b1;
                        state_d    = state_size'(S_BR1);
                    end
                    op_size'(OP_BRZ): begin
                        // Not taken: step PC over the unused target byte.
                        if (cu.zero) begin
                            sel1       = SEL1_PC;
                            sel2       = SEL2_BUS1;
                            load_add_r = 1'b1;
                            state_d    = state_size'(S_BR1);
                        end else begin
                            inc_pc  = 1'b1;
                            state_d = state_size'(S_FET1);
                        end
                    end
                    default: begin
                        state_d = state_size'(S_HALT);
                    end
                endcase
            end
            state_size'(S_EX1): begin
                sel1         = {1'b0, dest};
                sel2         = SEL2_ALU;
                load_reg_z   = 1'b1;
                load_r[dest] = 1'b1;
                state_d      = state_size'(S_FET1);
            end
            state_size'(S_RD1): begin
                sel2       = SEL2_MEM;
                load_add_r = 1'b1;
                inc_pc     = 1'b1;
                state_d    = state_size'(S_RD2);
            end
            state_size'(S_RD2): begin
                sel2         = SEL2_MEM;
                load_r[dest] = 1'b1;
                state_d      = state_size'(S_FET1);
            end
            state_size'(S_WR1): begin
                sel2       = SEL2_MEM;
                load_add_r = 1'b1;
                inc_pc     = 1'b1;
                state_d    = state_size'(S_WR2);
            end
            state_size'(S_WR2): begin
                sel1    = {1'b0, src};
                write   = 1'b1;
                state_d = state_size'(S_FET1);
            end
            state_size'(S_BR1): begin
                sel2       = SEL2_MEM;
                load_add_r = 1'b1;
                state_d    = state_size'(S_BR2);
            end
            state_size'(S_BR2): begin
                sel2    = SEL2_MEM;
                load_pc = 1'b1;
                state_d = state_size'(S_FET1);
            end
            state_size'(S_HALT): begin
                state_d = state_size'(S_HALT);
            end
            default: begin
                state_d = state_size'(S_HALT);
            end
        endcase
    end

    assign cu.load_r0       = load_r[0];
    assign cu.load_r1       = load_r[1];
    assign cu.load_r2       = load_r[2];
    assign cu.load_r3       = load_r[3];
    assign cu.load_pc       = load_pc;
    assign cu.inc_pc        = inc_pc;
    assign cu.load_ir       = load_ir;
    assign cu.load_add_r    = load_add_r;
    assign cu.load_reg_y    = load_reg_y;
    assign cu.load_reg_z    = load_reg_z;
    assign cu.write         = write;
    assign cu.sel_bus_1_mux = sel1;
    assign cu.sel_bus_2_mux = sel2;
    assign cu.state         = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: per-cycle expected outputs are queued
// when an instruction is presented and popped/compared each cycle.
module tb_control_unit;
    import cpu_pkg::*;

    typedef struct packed {
        logic [3:0]  st;
        logic [2:0]  s1;
        logic [1:0]  s2;
        logic [10:0] strb;
    } exp_t;

    typedef struct {
        logic [7:0] instr;
        logic       zero;
        int         n;
        exp_t       steps [3];
    } vec_t;

    // strobe bit order: r0 r1 r2 r3 pc inc ir add_r y z write
    localparam logic [10:0] B_NONE = 11'h000;
    localparam logic [10:0] B_R0   = 11'h400;
    localparam logic [10:0] B_R1   = 11'h200;
    localparam logic [10:0] B_R2   = 11'h100;
    localparam logic [10:0] B_R3   = 11'h080;
    localparam logic [10:0] B_PC   = 11'h040;
    localparam logic [10:0] B_INC  = 11'h020;
    localparam logic [10:0] B_IR   = 11'h010;
    localparam logic [10:0] B_ADDR = 11'h008;
    localparam logic [10:0] B_Y    = 11'h004;
    localparam logic [10:0] B_Z    = 11'h002;
    localparam logic [10:0] B_WR   = 11'h001;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    exp_t sb_q [$];
    vec_t vecs [10];

    control_unit_if #(.word_size(8), .state_size(4)) cu ();

    control_unit #(
        .word_size (8),
        .op_size   (4),
        .state_size(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cu (cu)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    function automatic exp_t mk(state_e st, logic [2:0] s1, logic [1:0] s2, logic [10:0] strb);
        exp_t e;
        e.st   = st;
        e.s1   = s1;
        e.s2   = s2;
        e.strb = strb;
        return e;
    endfunction

    function automatic exp_t actual();
        exp_t a;
        a.st   = cu.state;
        a.s1   = cu.sel_bus_1_mux;
        a.s2   = cu.sel_bus_2_mux;
        a.strb = {cu.load_r0, cu.load_r1, cu.load_r2, cu.load_r3, cu.load_pc,
                  cu.inc_pc, cu.load_ir, cu.load_add_r, cu.load_reg_y,
                  cu.load_reg_z, cu.write};
        return a;
    endfunction

    task automatic check_now(input string name);
        exp_t e;
        exp_t a;
        n_checks++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty, no expected value queued", name);
            return;
        end
        e = sb_q.pop_front();
        a = actual();
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: actual st=%0d sel1=%0d sel2=%0d strb=%b, required st=%0d sel1=%0d sel2=%0d strb=%b",
                     name, a.st, a.s1, a.s2, a.strb, e.st, e.s1, e.s2, e.strb);
        end
    endtask

    task automatic check_cycle(input string name);
        @(negedge clk);
        #1;
        check_now(name);
    endtask

    task automatic drain(input string name);
        while (sb_q.size() > 0) check_cycle(name);
    endtask

    // Present an instruction at the cycle that enters FET1 and queue the fetch.
    task automatic begin_instr(input logic [7:0] instr, input logic z);
        @(posedge clk);
        #1;
        cu.instruction = instr;
        cu.zero        = z;
        sb_q.push_back(mk(S_FET1, SEL1_PC, SEL2_BUS1, B_ADDR));
        sb_q.push_back(mk(S_FET2, SEL1_R0, SEL2_MEM, B_IR | B_INC));
    endtask

    task automatic set_vec(input int i, input logic [7:0] instr, input logic z, input int n,
                           input exp_t e0, input exp_t e1, input exp_t e2);
        vecs[i].instr    = instr;
        vecs[i].zero     = z;
        vecs[i].n        = n;
        vecs[i].steps[0] = e0;
        vecs[i].steps[1] = e1;
        vecs[i].steps[2] = e2;
    endtask

    initial begin
        exp_t nil;
        nil      = '0;
        n_checks = 0;
        n_fail   = 0;

        set_vec(0, 8'h00, 1'b0, 1, mk(S_DEC, 0, 0, B_NONE), nil, nil);
        set_vec(1, 8'h16, 1'b0, 2, mk(S_DEC, 1, 1, B_Y), mk(S_EX1, 2, 0, B_Z | B_R2), nil);
        set_vec(2, 8'h2D, 1'b1, 2, mk(S_DEC, 3, 1, B_Y), mk(S_EX1, 1, 0, B_Z | B_R1), nil);
        set_vec(3, 8'h30, 1'b0, 2, mk(S_DEC, 0, 1, B_Y), mk(S_EX1, 0, 0, B_Z | B_R0), nil);
        set_vec(4, 8'h49, 1'b0, 1, mk(S_DEC, 2, 0, B_Z | B_R1), nil, nil);
        set_vec(5, 8'h53, 1'b0, 3, mk(S_DEC, 4, 1, B_ADDR), mk(S_RD1, 0, 2, B_ADDR | B_INC),
                mk(S_RD2, 0, 2, B_R3));
        set_vec(6, 8'h64, 1'b0, 3, mk(S_DEC, 4, 1, B_ADDR), mk(S_WR1, 0, 2, B_ADDR | B_INC),
                mk(S_WR2, 1, 0, B_WR));
        set_vec(7, 8'h70, 1'b0, 3, mk(S_DEC, 4, 1, B_ADDR), mk(S_BR1, 0, 2, B_ADDR),
                mk(S_BR2, 0, 2, B_PC));
        set_vec(8, 8'h80, 1'b0, 1, mk(S_DEC, 0, 0, B_INC), nil, nil);
        set_vec(9, 8'h82, 1'b1, 3, mk(S_DEC, 4, 1, B_ADDR), mk(S_BR1, 0, 2, B_ADDR),
                mk(S_BR2, 0, 2, B_PC));

        rst            = 1'b1;
        cu.instruction = 8'h00;
        cu.zero        = 1'b0;

        sb_q.push_back(mk(S_IDLE, 0, 0, B_NONE));
        check_cycle("reset_state");
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb_q.push_back(mk(S_IDLE, 0, 0, B_NONE));
        check_cycle("idle_after_reset");

        for (int i = 0; i < 10; i++) begin
            begin_instr(vecs[i].instr, vecs[i].zero);
            for (int k = 0; k < vecs[i].n; k++) sb_q.push_back(vecs[i].steps[k]);
            drain($sformatf("vec%0d_op%02h", i, vecs[i].instr));
        end

        // Illegal opcode: HALT must hold for 20 cycles.
        begin_instr(8'hF0, 1'b0);
        sb_q.push_back(mk(S_DEC, 0, 0, B_NONE));
        for (int k = 0; k < 20; k++) sb_q.push_back(mk(S_HALT, 0, 0, B_NONE));
        drain("halt_sticky");

        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        sb_q.push_back(mk(S_IDLE, 0, 0, B_NONE));
        check_now("halt_async_reset");
        @(posedge clk);
        #1;
        sb_q.push_back(mk(S_IDLE, 0, 0, B_NONE));
        check_now("halt_reset_held");
        rst = 1'b0;
        sb_q.push_back(mk(S_IDLE, 0, 0, B_NONE));
        check_cycle("halt_release_idle");
        begin_instr(8'h00, 1'b0);
        sb_q.push_back(mk(S_DEC, 0, 0, B_NONE));
        drain("halt_recover_nop");

        // Abort a write in WR1 with an asynchronous reset.
        begin_instr(8'h64, 1'b0);
        sb_q.push_back(mk(S_DEC, 4, 1, B_ADDR));
        sb_q.push_back(mk(S_WR1, 0, 2, B_ADDR | B_INC));
        drain("wr_abort_pre");
        #2;
        rst = 1'b1;
        #1;
        sb_q.push_back(mk(S_IDLE, 0, 0, B_NONE));
        check_now("wr_abort_async");
        @(posedge clk);
        #1;
        sb_q.push_back(mk(S_IDLE, 0, 0, B_NONE));
        check_now("wr_abort_no_write");
        rst = 1'b0;
        sb_q.push_back(mk(S_IDLE, 0, 0, B_NONE));
        check_cycle("wr_abort_idle");
        begin_instr(8'h53, 1'b0);
        sb_q.push_back(mk(S_DEC, 4, 1, B_ADDR));
        sb_q.push_back(mk(S_RD1, 0, 2, B_ADDR | B_INC));
        sb_q.push_back(mk(S_RD2, 0, 2, B_R3));
        drain("wr_abort_recover_rd");

        begin_instr(8'h00, 1'b0);
        sb_q.push_back(mk(S_DEC, 0, 0, B_NONE));
        drain("final_nop");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter word_size, default 8, SHALL set the instruction width in bits.
REQ-002 Parameter op_size, default 4, SHALL set the opcode width, taken as instruction[word_size-1:word_size-op_size].
REQ-003 Parameter state_size, default 4, SHALL set the state register width.
REQ-004 Port clk, input, 1: the single clock; all state updates SHALL occur on its rising edge.
REQ-005 Port rst, input, 1: reset SHALL be asynchronous and active-high.
REQ-006 Port instruction, input, word_size: IR contents; src=[3:2], dest=[1:0].
REQ-007 Port zero, input, 1: ALU zero flag from the datapath.
REQ-008 Ports load_r0, load_r1, load_r2, load_r3, load_pc, inc_pc, load_ir, load_add_r, load_reg_y, load_reg_z, write: output, 1 bit each, datapath strobes.
REQ-009 Port sel_bus_1_mux, output, 3: select for the 5-channel bus-1 mux; 0=R0, 1=R1, 2=R2, 3=R3, 4=PC.
REQ-010 Port sel_bus_2_mux, output, 2: select for the bus-2 mux; 0=ALU, 1=bus_1, 2=mem.
REQ-011 Port state, output, state_size: current state, for debug.

Function
REQ-012 Opcodes SHALL be: NOP=0, ADD=1, SUB=2, AND=3, NOT=4, RD=5, WR=6, BR=7, BRZ=8; all others are illegal.
REQ-013 States SHALL be: IDLE, FET1, FET2, DEC, EX1, RD1, RD2, WR1, WR2, BR1, BR2, HALT.
REQ-014 Outputs SHALL be combinational from state, instruction and zero; every strobe defaults to 0 and both selects default to 0 in every state.
REQ-015 IDLE -> FET1 unconditionally, with no strobes asserted.
REQ-016 FET1: sel1=PC, sel2=bus_1, load_add_r=1; -> FET2.
REQ-017 FET2: sel2=mem, load_ir=1, inc_pc=1; -> DEC.
REQ-018 DEC NOP: -> FET1, no strobes.
REQ-019 DEC ADD/SUB/AND: sel1=src, sel2=bus_1, load_reg_y=1; -> EX1.
REQ-020 DEC NOT: sel1=src, load_reg_z=1, sel2=ALU, load_r[dest]=1; -> FET1.
REQ-021 DEC RD/WR/BR: sel1=PC, sel2=bus_1, load_add_r=1; -> RD1/WR1/BR1 respectively.
REQ-022 DEC BRZ, zero=1: behaves as BR (-> BR1); zero=0: inc_pc=1 only (skip operand byte); -> FET1.
REQ-023 DEC illegal opcode: -> HALT, no strobes.
REQ-024 EX1: sel1=dest, load_reg_z=1, sel2=ALU, load_r[dest]=1; -> FET1.
REQ-025 RD1: sel2=mem, load_add_r=1, inc_pc=1; -> RD2.
REQ-026 RD2: sel2=mem, load_r[dest]=1; -> FET1.
REQ-027 WR1: sel2=mem, load_add_r=1, inc_pc=1; -> WR2.
REQ-028 WR2: sel1=src, write=1; -> FET1.
REQ-029 BR1: sel2=mem, load_add_r=1; -> BR2.
REQ-030 BR2: sel2=mem, load_pc=1; -> FET1.
REQ-031 HALT SHALL be sticky, with no strobes, until rst is asserted.
REQ-032 At most one load_r* SHALL be high in any cycle; load_pc and inc_pc SHALL never both be high.
REQ-033 Unused state encodings SHALL transition to HALT.
REQ-034 Instruction latency SHALL be: NOP=3, NOT=3, ALU op=4, RD/WR/BR=5, BRZ taken=5, BRZ not taken=3 cycles, counted from FET1.

Reset
REQ-035 rst=1 SHALL force state=IDLE immediately, independent of clk, driving all strobes to 0 and both selects to 0.
REQ-036 rst asserted mid-instruction SHALL abort it with no further strobes; after release, FET1 SHALL follow on the first rising edge.

Structure
REQ-037 Opcode, state and mux-select encodings SHALL live in a shared package, cpu_pkg, also used by the datapath muxes.
REQ-038 The block SHALL be a single module with a state register and a next-state/output decode; no sub-module is required.

Verification
REQ-039 Reset, then instruction=8'h00 (NOP): state sequence IDLE,FET1,FET2,DEC,FET1; load_ir=1 only in FET2.
REQ-040 instruction=8'h16 (ADD src=1, dest=2): DEC sel1=1 with load_reg_y=1; EX1 sel1=2, sel2=0, load_r2=1.
REQ-041 instruction=8'h53 (RD dest=3): RD1 inc_pc=1; RD2 sel2=2, load_r3=1; total 5 cycles.
REQ-042 instruction=8'h80 (BRZ): zero=0 -> DEC inc_pc=1, then FET1; zero=1 -> BR2 load_pc=1.
REQ-043 instruction=8'hF0: HALT is reached and held for 20 cycles; rst pulse -> IDLE, then FET1.
REQ-044 rst asserted asynchronously during WR1: write never asserts; all outputs are 0 before the next clk edge.
